// File: rtl/rr_mux_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner selection for a shared N:1 mux with a hold limit,
// registered grant/select and a registered muxed output channel.
module rr_mux_arbiter #(
    parameter  int N        = 4,
    parameter  int WIDTH    = 8,
    parameter  int MAX_HOLD = 8,
    localparam int SELW     = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic [N-1:0]         gnt,
    output logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_n;
    logic [SELW-1:0] ptr, ptr_n, sel_n, ptr_adv;
    logic [HW-1:0]   hold, hold_n;
    logic [N-1:0]    gnt_n, own;
    logic [SELW:0]   win;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [SELW:0] pick(
        input logic [N-1:0]    cand,
        input logic [SELW-1:0] start
    );
        logic            found;
        logic [SELW-1:0] idx;
        int              k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = (int'(start) + i) % N;
            if (!found && cand[k]) begin
                found = 1'b1;
                idx   = SELW'(k);
            end
        end
        return {found, idx};
    endfunction

    assign own     = ONE << sel;
    assign ptr_adv = (sel == SELW'(N - 1)) ? '0 : sel + SELW'(1);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold;
        win     = '0;
        unique case (state)
            IDLE: begin
                win = pick(req, ptr);
                if (win[SELW]) begin
                    state_n = BUSY;
                    sel_n   = win[SELW-1:0];
                    hold_n  = '0;
                end
            end
            BUSY: begin
                if (!req[sel]) begin
                    ptr_n = ptr_adv;
                    win   = pick(req, ptr_adv);
                    if (win[SELW]) begin
                        sel_n  = win[SELW-1:0];
                        hold_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (hold == HOLD_LAST && |(req & ~own)) begin
                    ptr_n  = ptr_adv;
                    win    = pick(req & ~own, ptr_adv);
                    sel_n  = win[SELW-1:0];
                    hold_n = '0;
                end else if (hold != HOLD_LAST) begin
                    hold_n = hold + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == BUSY) ? (ONE << sel_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            hold  <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
            gnt   <= gnt_n;
        end
    end

    // Only a cycle where the owner still requests moves data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == BUSY) && req[sel];
            if ((state == BUSY) && req[sel])
                out_data <= data_in[int'(sel)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
`timescale 1ns/1ps
// Directed bench for rr_mux_arbiter; grants checked per edge,
// transferred data checked by a scoreboard monitor.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic           out_valid;
    logic [W-1:0]   out_data;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] sb[$];
    logic [N-1:0] cur_exp;
    logic [N-1:0] rv, ev;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .data_in(data_in),
        .gnt(gnt),
        .sel(sel),
        .out_valid(out_valid),
        .out_data(out_data)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [W-1:0] dval(input int i);
        case (i)
            0:       return 8'h11;
            1:       return 8'h22;
            2:       return 8'hA5;
            default: return 8'h44;
        endcase
    endfunction

    // Drive req for one cycle; e is the grant expected after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] e,
                        input string nm);
        logic xfer;
        req  = r;
        xfer = (cur_exp & r) != '0;
        if (xfer) sb.push_back(dval(oh2i(cur_exp)));
        @(posedge clk);
        #1;
        chk({nm, "_gnt"}, 32'(gnt), 32'(e));
        if (e != '0) chk({nm, "_sel"}, 32'(sel), 32'(oh2i(e)));
        chk({nm, "_vld"}, 32'(out_valid), 32'(xfer));
        cur_exp = e;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got data %0h expected none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
        cur_exp = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        rst_n = 1'b1;
        step(4'b1111, 4'b0001, "rst_rel");

        // round robin 0,1,2,3,0 with no idle gaps
        step(4'b1111, 4'b0001, "rr0");
        step(4'b1110, 4'b0010, "rr1");
        step(4'b1111, 4'b0010, "rr1b");
        step(4'b1101, 4'b0100, "rr2");
        step(4'b1111, 4'b0100, "rr2b");
        step(4'b1011, 4'b1000, "rr3");
        step(4'b1111, 4'b1000, "rr3b");
        step(4'b0111, 4'b0001, "rr4");

        // single requester
        step(4'b0000, 4'b0000, "s_idle");
        step(4'b0100, 4'b0100, "s_gnt");
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0100, "s_hold");
        step(4'b0000, 4'b0000, "s_drop");
        step(4'b0000, 4'b0000, "s_idle2");

        // hold limit: exactly 8 granted cycles for owner 0
        step(4'b0001, 4'b0001, "h_gnt");
        step(4'b0001, 4'b0001, "h_c1");
        for (int i = 0; i < 6; i++) step(4'b0011, 4'b0001, "h_cn");
        step(4'b0011, 4'b0010, "h_rot");
        step(4'b0001, 4'b0001, "a_sw");
        for (int i = 0; i < 12; i++) step(4'b0001, 4'b0001, "a_alone");

        // wrap-around
        step(4'b1000, 4'b1000, "w_3");
        step(4'b1000, 4'b1000, "w_3b");
        step(4'b0101, 4'b0001, "w_0");
        step(4'b0101, 4'b0001, "w_0b");
        step(4'b0100, 4'b0100, "w_2");
        step(4'b0000, 4'b0000, "w_idle");

        // all (req0, req1, start ptr) combinations
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 4; r++) begin
                if (p == 0) begin
                    step(4'b1000, 4'b1000, "dc_set");
                end else begin
                    step(4'b0001, 4'b0001, "dc_set");
                end
                step(4'b0000, 4'b0000, "dc_ptr");
                rv = 4'(r);
                ev = (r == 0) ? 4'b0000 :
                     (r == 1) ? 4'b0001 :
                     (r == 2) ? 4'b0010 :
                     (p == 0) ? 4'b0001 : 4'b0010;
                step(rv, ev, "dc_gnt");
                step(rv, ev, "dc_xfer");
                step(4'b0000, 4'b0000, "dc_rel");
            end
        end

        // async reset while a transfer is live
        step(4'b0010, 4'b0010, "m_gnt");
        step(4'b0010, 4'b0010, "m_xfer");
        req = 4'b1111;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_gnt", 32'(gnt), 0);
        chk("mrst_sel", 32'(sel), 0);
        chk("mrst_vld", 32'(out_valid), 0);
        chk("mrst_data", 32'(out_data), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cur_exp = '0;
        step(4'b1111, 4'b0001, "post_rst");
        step(4'b0000, 4'b0000, "post_rel");
        @(posedge clk);
        #1;

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one N:1 data mux between N requesters. It picks one owner at a time and drives the mux select and a one-hot grant. It registers the muxed data onto a single output channel. A hold limit stops one requester from monopolising the mux while others wait. It sits in front of the shared mux datapath and replaces hand-driven select lines.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, data width per requester
MAX_HOLD, 8, max consecutive granted cycles before forced rotation when others are waiting (>=1)
SELW, $clog2(N), select width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  N  request per requester, level-sensitive
data_in  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
gnt  output  N  one-hot grant (all-zero when idle), registered
sel  output  SELW  mux select = index of current owner, registered
out_valid  output  1  registered: owner's data transferred last cycle
out_data  output  WIDTH  registered muxed data, valid when out_valid=1

Behaviour:
- Reset (rst_n=0, async): state=IDLE, gnt=0, sel=0, ptr=0, hold_cnt=0, out_valid=0, out_data=0. Deassertion is sampled at the next clk edge. Reset mid-grant drops gnt/out_valid immediately; no data is kept.
- States: IDLE (no owner) and BUSY (owner = sel, gnt[sel]=1).
- Priority search: the first set bit of the candidate vector, scanning from index ptr upward and wrapping modulo N.
- IDLE:
  - If any req is set at an edge: gnt/sel load the winner (search over req), hold_cnt=0, go to BUSY.
  - Else stay in IDLE.
  - Grant latency: 1 cycle from req sampled to gnt visible.
- BUSY, each edge, evaluated in this order:
  - (a) req[sel]=0 → release. ptr=sel+1 mod N. Search req with the new ptr. If a winner exists, grant it directly (no idle bubble) with hold_cnt=0. Else go to IDLE with gnt=0.
  - (b) req[sel]=1, hold_cnt==MAX_HOLD-1, and another req is set → forced rotation. ptr=sel+1 mod N. Search req with bit sel masked. Grant the winner with hold_cnt=0.
  - (c) Otherwise keep the owner; hold_cnt increments, saturating at MAX_HOLD-1.
- Datapath:
  - Each edge: out_valid <= (state==BUSY && req[sel]).
  - When that holds, out_data <= data_in[sel]; otherwise out_data holds its last value.
  - Data latency: 1 cycle after a granted cycle.
- gnt is always one-hot or zero, and always equals (1<<sel) when BUSY.
- A requester that drops req loses the grant on the next edge. Its data from that dropped cycle is not transferred.
- A simultaneous release and new request from the same index are treated as a release. The index is re-eligible in the same search only if no other requester exists (the search starts at sel+1 and wraps).
- ptr advances only on release or forced rotation, never in IDLE.
- X/Z on req during reset is ignored.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with req=4'b1111 → gnt=0, sel=0, out_valid=0, out_data=0 immediately. After release, gnt=4'b0001 one edge later.
- Single requester: req=4'b0100, data_in[2]=8'hA5, held for 3 cycles → gnt=4'b0100 from edge 1. out_valid=1 with out_data=8'hA5 on edges 2–4. req drops → gnt=0 next edge, out_valid=0 one edge after the last granted cycle.
- Round robin: req=4'b1111, each requester drops after 2 granted cycles then re-raises → grant order 0,1,2,3,0 with no idle cycles between owners.
- Hold limit: MAX_HOLD=8, req[0] held continuously, req[1] raised at grant cycle 2 → owner 0 gets exactly 8 granted cycles, then gnt=4'b0010. Alone (req=4'b0001), owner 0 keeps the grant indefinitely.
- Wrap-around: owner 3 releases while req=4'b0101 → next gnt=4'b0001 (search wraps from ptr=0). Then ptr=1 on its release → gnt=4'b0100.
- Data check: for all 8 combinations of (req[0], req[1], start ptr) with data_in[0]=8'h11, data_in[1]=8'h22 → out_data always equals the data of the index in sel one cycle earlier. Zero mismatches reported.
